sdram_responder: RTL
====================

// Module: sdram_responder
// PURPOSE
//  Synthesizable SDRAM device responder: the chip side of the SDRAM pin bus driven by our
//  SDRAM controller. Decodes RAS#/CAS#/WE# commands, tracks init, mode register and
//  per-bank open rows, and serves single-beat reads/writes from a byte-enabled on-chip
//  RAM. Flags protocol/timing violations. Used as an FPGA loopback target and as the DUT
//  partner in controller benches.
// PARAMETERS
//  DATA_WIDTH     32  DQ width; multiple of 8
//  ROW_WIDTH      11  row address bits (A[ROW_WIDTH-1:0])
//  COL_WIDTH      8   column bits (A[COL_WIDTH-1:0])
//  BANK_WIDTH     2   bank bits
//  MEM_ADDR_WIDTH 12  backing RAM depth (words); {ba,row,col} truncated to low bits (aliasing)
//  T_RCD          1   min cycles ACTIVE -> READ/WRITE, same bank
//  T_RC           4   min cycles REFRESH -> any command
// PORTS
//  clk             in   1          SDRAM clock; commands sampled on rising edge
//  reset           in   1          async, active-high
//  sdram_cs_n      in   1          chip select; high = NOP
//  sdram_ras_n     in   1          command bit
//  sdram_cas_n     in   1          command bit
//  sdram_wen_n     in   1          command bit
//  sdram_ba        in   BANK_WIDTH bank address
//  sdram_addr      in   ROW_WIDTH  row / column / mode / A10 precharge-all
//  sdram_dqm       in   DATA_WIDTH/8 write byte mask, 1 = keep byte
//  sdram_dq_in     in   DATA_WIDTH write data
//  sdram_dq_out    out  DATA_WIDTH read data
//  sdram_dq_oe     out  1          1 = responder drives DQ
//  initialised     out  1          init sequence complete
//  cas_latency     out  2          CAS latency from mode register (2 or 3)
//  refresh_count   out  16         AUTO REFRESH count since init, wraps
//  protocol_error  out  1          sticky violation flag
//  error_code      out  4          code of FIRST violation since reset
// BEHAVIOUR
//  Reset: all outputs 0, cas_latency=2, banks closed, init state POWERUP, read pipe flushed.
//   Reset mid-read drops sdram_dq_oe immediately. RAM contents not cleared.
//  Commands {ras,cas,we}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 111 NOP;
//   cs_n=1 or 110 (burst stop) = NOP.
//  Init FSM: POWERUP -(PRE with A10=1)-> PRECHARGED -(REF)-> REF1 -(REF)-> REF2 -(MRS)-> READY.
//   Extra REF in REF2 allowed. Any ACT/RD/WR before READY -> error 1.
//  MRS: all banks closed else error 2. A[6:4]=2/3 -> cas_latency; other -> error 3 (keep old).
//   A[2:0]!=0 (burst length != 1) -> error 3. MRS also allowed in READY.
//  ACT: bank open -> error 4 (row unchanged); else open bank, store row, reset its tRCD counter.
//  RD/WR: bank closed -> error 5, ignored; issued < T_RCD cycles after ACT -> error 6,
//   still executed. Word = {ba,row,col}[MEM_ADDR_WIDTH-1:0]. A10=1: bank closes same edge.
//  WR: dq_in sampled on the WR edge; byte i written iff dqm[i]=0. WR while a read is pending
//   or being driven -> error 7, write still performed.
//  RD: RAM read 1 cycle; dq_out/dq_oe registered so they update at edge n+CL-1 (n=RD edge),
//   asserted exactly one cycle, stable across edge n+CL. Back-to-back RDs pipeline, one per
//   cycle. dqm ignored on reads. CL change with reads in flight: in-flight reads keep old CL.
//  PRE: A10=1 closes all banks, else bank ba. PRE of closed bank is legal (no-op).
//  REF: any bank open -> error 8; else refresh_count+1 (mod 2^16). Any command other than
//   NOP within T_RC cycles after REF -> error 9, command still executed.
//  RD and WR same bank/word on consecutive edges: read after write returns new data.
//  Errors: protocol_error sticky until reset; error_code latches first only; 0 = none.
// STRUCTURE
//  Package sdram_pkg: cmd_t enum (MRS/REF/PRE/ACT/WR/RD/NOP), init_state_t,
//   err_code_t (ERR_NONE=0..ERR_TRC=9), localparams for mode-register field positions.
//  Sub-module sdram_responder_mem: single-port RAM, byte write enables, 1-cycle sync read,
//   2**MEM_ADDR_WIDTH x DATA_WIDTH. Top holds decode, init FSM, bank table, timers, read pipe.
// TESTING
//  1 Init (PRE-all, REF, REF, MRS A=0x020) -> initialised=1, cas_latency=2, error_code=0.
//  2 CL2: ACT b1 r5; WR c3 0xDEADBEEF dqm=0; ACT b1 r5; RD c3 A10=1 at edge n ->
//    dq_oe=1, dq_out=0xDEADBEEF sampled at edge n+2 only; bank1 closed after RD.
//  3 Byte mask: over 0xDEADBEEF write 0x11223344 dqm=4'b1100 -> read 0xDEAD3344.
//  4 MRS A=0x030 then RD -> data at edge n+3; two back-to-back RDs -> two consecutive beats.
//  5 RD before init -> error_code=1, dq_oe stays 0; then ACT on open bank -> code still 1.
//  6 Assert reset during CL3 read -> dq_oe=0 next sample, initialised=0, RD after
//    release -> error 1; REF with bank open after re-init -> error 8, refresh_count unchanged.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM responder: command decode, init states, error codes
// and mode-register field positions.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } cmd_t;

  typedef enum logic [2:0] {
    INIT_POWERUP,
    INIT_PRECHARGED,
    INIT_REF1,
    INIT_REF2,
    INIT_READY
  } init_state_t;

  typedef enum logic [3:0] {
    ERR_NONE        = 4'd0,
    ERR_NOT_INIT    = 4'd1,
    ERR_MRS_OPEN    = 4'd2,
    ERR_MODE        = 4'd3,
    ERR_ACT_OPEN    = 4'd4,
    ERR_BANK_CLOSED = 4'd5,
    ERR_TRCD        = 4'd6,
    ERR_RW_COLLIDE  = 4'd7,
    ERR_REF_OPEN    = 4'd8,
    ERR_TRC         = 4'd9
  } err_code_t;

  // Mode register / address bit positions
  localparam int MR_BL_LSB = 0;
  localparam int MR_BL_MSB = 2;
  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;
  localparam int AP_BIT    = 10;

  // Burst stop and deselect both behave as NOP for a single-beat device.
  function automatic cmd_t decode_cmd(input logic cs_n, input logic [2:0] rcw);
    if (cs_n || rcw == 3'b110) return CMD_NOP;
    return cmd_t'(rcw);
  endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// Backing store: single-port RAM with per-byte write enables and a registered read.
module sdram_responder_mem
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-masked write and 1-cycle synchronous read; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM chip-side responder: command decode, init sequence, bank/row tracking,
// tRCD/tRC timers, CAS-latency read pipe and sticky protocol error reporting.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ROW_WIDTH      = 11,
  parameter int COL_WIDTH      = 8,
  parameter int BANK_WIDTH     = 2,
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int T_RCD          = 1,
  parameter int T_RC           = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sdram_cs_n,
  input  logic                    sdram_ras_n,
  input  logic                    sdram_cas_n,
  input  logic                    sdram_wen_n,
  input  logic [BANK_WIDTH-1:0]   sdram_ba,
  input  logic [ROW_WIDTH-1:0]    sdram_addr,
  input  logic [DATA_WIDTH/8-1:0] sdram_dqm,
  input  logic [DATA_WIDTH-1:0]   sdram_dq_in,
  output logic [DATA_WIDTH-1:0]   sdram_dq_out,
  output logic                    sdram_dq_oe,
  output logic                    initialised,
  output logic [1:0]              cas_latency,
  output logic [15:0]             refresh_count,
  output logic                    protocol_error,
  output logic [3:0]              error_code
);

  localparam int NB     = 1 << BANK_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [3:0] TRC_RELOAD = 4'(T_RC - 1);

  cmd_t cmd;
  logic ap;
  assign cmd = decode_cmd(sdram_cs_n, {sdram_ras_n, sdram_cas_n, sdram_wen_n});
  assign ap  = sdram_addr[AP_BIT];

  init_state_t                     init_q, init_d;
  logic [1:0]                      cl_q, cl_d;
  logic [NB-1:0]                   open_q, open_d;
  logic [NB-1:0][ROW_WIDTH-1:0]    row_q, row_d;
  logic [NB-1:0][3:0]              trcd_q, trcd_d;
  logic [3:0]                      trc_q, trc_d;
  logic [15:0]                     ref_cnt_q, ref_cnt_d;
  logic                            perr_q, perr_d;
  err_code_t                       ecode_q, ecode_d;

  // Read pipe: s1 = RAM access in flight, s2 = extra delay stage for CL3
  logic                  s1_vld_q, s1_cl3_q, s2_vld_q, oe_q;
  logic [DATA_WIDTH-1:0] s2_data_q, dq_q;

  logic                      mem_we, mem_re;
  logic [NBYTES-1:0]         mem_be;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  err_code_t err;
  logic      any_open, ready, rd_busy;
  logic [4:0] elapsed;

  assign any_open = |open_q;
  assign ready    = (init_q == INIT_READY);
  assign rd_busy  = s1_vld_q | s2_vld_q | oe_q;
  // Cycles since ACT on the addressed bank (counter is 0 on the edge after ACT)
  assign elapsed  = {1'b0, trcd_q[sdram_ba]} + 5'd1;

  // Command execution, init FSM next state, timers and error selection
  always_comb begin
    init_d    = init_q;
    cl_d      = cl_q;
    open_d    = open_q;
    row_d     = row_q;
    ref_cnt_d = ref_cnt_q;
    perr_d    = perr_q;
    ecode_d   = ecode_q;
    err       = ERR_NONE;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = '0;
    mem_addr  = MEM_ADDR_WIDTH'({sdram_ba, row_q[sdram_ba], sdram_addr[COL_WIDTH-1:0]});
    trc_d     = (trc_q != 4'd0) ? trc_q - 4'd1 : 4'd0;
    for (int b = 0; b < NB; b++) begin
      trcd_d[b] = (trcd_q[b] != 4'hF) ? trcd_q[b] + 4'd1 : trcd_q[b];
    end

    case (cmd)
      CMD_MRS: begin
        if (any_open) err = ERR_MRS_OPEN;
        else begin
          if (sdram_addr[MR_CL_MSB:MR_CL_LSB] == 3'd2 || sdram_addr[MR_CL_MSB:MR_CL_LSB] == 3'd3)
            cl_d = sdram_addr[MR_CL_LSB+1:MR_CL_LSB];
          else
            err = ERR_MODE;
          if (sdram_addr[MR_BL_MSB:MR_BL_LSB] != 3'd0) err = ERR_MODE;
          if (init_q == INIT_REF2) init_d = INIT_READY;
        end
      end
      CMD_REF: begin
        if (any_open) err = ERR_REF_OPEN;
        else begin
          ref_cnt_d = ref_cnt_q + 16'd1;
          trc_d     = TRC_RELOAD;
          if (init_q == INIT_PRECHARGED) init_d = INIT_REF1;
          else if (init_q == INIT_REF1) init_d = INIT_REF2;
        end
      end
      CMD_PRE: begin
        if (ap) open_d = '0;
        else    open_d[sdram_ba] = 1'b0;
        if (init_q == INIT_POWERUP && ap) init_d = INIT_PRECHARGED;
      end
      CMD_ACT: begin
        if (!ready) err = ERR_NOT_INIT;
        else if (open_q[sdram_ba]) err = ERR_ACT_OPEN;
        else begin
          open_d[sdram_ba] = 1'b1;
          row_d[sdram_ba]  = sdram_addr;
          trcd_d[sdram_ba] = 4'd0;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!ready) err = ERR_NOT_INIT;
        else if (!open_q[sdram_ba]) err = ERR_BANK_CLOSED;
        else begin
          if (elapsed < 5'(T_RCD)) err = ERR_TRCD;
          else if (cmd == CMD_WR && rd_busy) err = ERR_RW_COLLIDE;
          if (ap) open_d[sdram_ba] = 1'b0;
          if (cmd == CMD_WR) begin
            mem_we = 1'b1;
            mem_be = ~sdram_dqm;
          end else begin
            mem_re = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // tRC is reported only when the command itself was clean
    if (cmd != CMD_NOP && trc_q != 4'd0 && err == ERR_NONE) err = ERR_TRC;

    if (err != ERR_NONE) begin
      perr_d = 1'b1;
      if (!perr_q) ecode_d = err;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q    <= INIT_POWERUP;
      cl_q      <= 2'd2;
      open_q    <= '0;
      row_q     <= '0;
      trcd_q    <= '0;
      trc_q     <= '0;
      ref_cnt_q <= '0;
      perr_q    <= 1'b0;
      ecode_q   <= ERR_NONE;
    end else begin
      init_q    <= init_d;
      cl_q      <= cl_d;
      open_q    <= open_d;
      row_q     <= row_d;
      trcd_q    <= trcd_d;
      trc_q     <= trc_d;
      ref_cnt_q <= ref_cnt_d;
      perr_q    <= perr_d;
      ecode_q   <= ecode_d;
    end
  end

  // Read pipe: each read carries the CL captured at issue, so a later MRS cannot retime it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_cl3_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      oe_q      <= 1'b0;
      dq_q      <= '0;
    end else begin
      s1_vld_q  <= mem_re;
      s1_cl3_q  <= (cl_q == 2'd3);
      s2_vld_q  <= s1_vld_q & s1_cl3_q;
      s2_data_q <= mem_rdata;
      oe_q      <= (s1_vld_q & ~s1_cl3_q) | s2_vld_q;
      if (s2_vld_q)                    dq_q <= s2_data_q;
      else if (s1_vld_q && !s1_cl3_q)  dq_q <= mem_rdata;
    end
  end

  sdram_responder_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .be_i    (mem_be),
    .addr_i  (mem_addr),
    .wdata_i (sdram_dq_in),
    .rdata_o (mem_rdata)
  );

  assign sdram_dq_out   = dq_q;
  assign sdram_dq_oe    = oe_q;
  assign initialised    = ready;
  assign cas_latency    = cl_q;
  assign refresh_count  = ref_cnt_q;
  assign protocol_error = perr_q;
  assign error_code     = ecode_q;

endmodule
